// File: rtl/inv_sub_bytes_serial.sv
// inv_sub_bytes_serial
//   Inverse SubBytes stage of the AES decryption datapath. A 128-bit state is
//   accepted over a valid/ready handshake. Its 16 bytes are substituted
//   NUM_SBOX at a time through NUM_SBOX copies of inv_s_box. The result is
//   held until the downstream stage accepts it.
//
//   Ports
//     clk        system clock, rising edge
//     rst        asynchronous active-high reset
//     clear      synchronous flush back to IDLE; the in-flight state is dropped
//     in_state   state from upstream; byte i = in_state[127-8i -: 8]
//     in_valid   in_state is valid
//     in_ready   block can accept a state this cycle
//     out_state  substituted state, same byte order as in_state
//     out_valid  out_state is valid
//     out_ready  downstream accepts out_state
//
//   Parameter
//     NUM_SBOX   S-box copies / bytes per cycle: 1, 2, 4, 8 or 16

// inv_s_box
//   Inverse Rijndael S-box as a constant lookup table.
//   Ports: a = input byte, y = substituted byte.
module inv_s_box (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Entry k is the inverse substitution of byte value k (row-major, MSB first).
  localparam logic [0:255][7:0] INV_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign y = INV_TBL[a];

endmodule

module inv_sub_bytes_serial #(
  parameter int NUM_SBOX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [127:0] in_state,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out_state,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int GROUPS = 16 / NUM_SBOX;
  localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int GW     = NUM_SBOX * 8;
  localparam logic [CW-1:0] LAST = CW'(GROUPS - 1);

  if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4 ||
        NUM_SBOX == 8 || NUM_SBOX == 16)) begin : g_bad_num_sbox
    $error("inv_sub_bytes_serial: NUM_SBOX must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t  state;
  logic [CW-1:0] cnt;
  logic          rdy_q;

  // Group 0 sits in the top bits, which keeps the FIPS byte order: group g
  // holds bytes g*NUM_SBOX .. g*NUM_SBOX+NUM_SBOX-1.
  logic [0:GROUPS-1][GW-1:0] in_buf;
  logic [0:GROUPS-1][GW-1:0] out_q;

  logic [0:NUM_SBOX-1][7:0] lane_in;
  logic [0:NUM_SBOX-1][7:0] lane_out;

  assign lane_in = in_buf[cnt];

  for (genvar l = 0; l < NUM_SBOX; l++) begin : g_lane
    inv_s_box u_sbox (
      .a (lane_in[l]),
      .y (lane_out[l])
    );
  end

  // clear blocks acceptance combinationally, so an in_valid that coincides
  // with a flush is never captured.
  assign in_ready  = rdy_q & ~clear;
  assign out_state = out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rdy_q     <= 1'b1;
      out_valid <= 1'b0;
      in_buf    <= '0;
      out_q     <= '0;
    end else if (clear) begin
      // out_q keeps its contents; only the control path is flushed.
      state     <= IDLE;
      cnt       <= '0;
      rdy_q     <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && rdy_q) begin
            in_buf <= in_state;
            cnt    <= '0;
            rdy_q  <= 1'b0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          out_q[cnt] <= lane_out;
          if (cnt == LAST) begin
            // Counter parks on the last group; capture re-zeroes it.
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          // in_ready rises only after the output handshake edge.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            rdy_q     <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          rdy_q     <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_serial.sv
// Self-checking bench for inv_sub_bytes_serial. The reference inverse S-box
// is derived from GF(2^8) arithmetic and the forward affine map. A cycle-level
// behavioural model checks the NUM_SBOX=4 instance on every cycle. Four more
// instances cover the other legal widths.
module tb_inv_sub_bytes_serial;

  localparam int NS = 4;
  localparam logic [127:0] VEC  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] VEXP = 128'h52096ad53036a538bf40a39e81f3d7fb;

  logic         clk, rst, rst_s, clear, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_state, out_state;

  int checks = 0;
  int failures = 0;
  int sub_done = 0;
  logic [7:0] invtab [256];

  inv_sub_bytes_serial #(.NUM_SBOX(NS)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_state  (in_state),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_state (out_state),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    return 8'((v << k) | (v >> (8 - k)));
  endfunction

  // Forward S-box: multiplicative inverse (a^254) followed by the affine map.
  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    if (x == 8'h00) inv = 8'h00;
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  initial begin
    for (int x = 0; x < 256; x++) invtab[fwd_sbox(8'(x))] = 8'(x);
  end

  function automatic logic [127:0] inv_sub(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = invtab[v[127-8*i -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  bit           m_busy = 0, m_valid = 0;
  int           m_rem = 0, acc = 0, dlv = 0;
  logic [127:0] m_pend, m_data;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      m_busy  = 0;
      m_valid = 0;
      m_rem   = 0;
    end else begin
      chk("cyc_in_ready", in_ready, !m_busy && !m_valid && !clear);
      chk("cyc_out_valid", out_valid, m_valid);
      if (m_valid) chk("cyc_out_state", out_state, m_data);
      // what the next rising edge does
      if (clear) begin
        m_busy  = 0;
        m_valid = 0;
      end else if (m_valid) begin
        if (out_ready) begin
          m_valid = 0;
          dlv++;
        end
      end else if (m_busy) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy  = 0;
          m_valid = 1;
          m_data  = m_pend;
        end
      end else if (in_valid) begin
        m_busy = 1;
        m_rem  = 16 / NS;
        m_pend = inv_sub(in_state);
        acc++;
      end
    end
  end

  // ---------------- other widths ----------------
  for (genvar g = 0; g < 4; g++) begin : g_alt
    localparam int P = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
    logic         s_in_valid, s_in_ready, s_out_valid;
    logic [127:0] s_in, s_out;

    inv_sub_bytes_serial #(.NUM_SBOX(P)) u_dut (
      .clk       (clk),
      .rst       (rst_s),
      .clear     (1'b0),
      .in_state  (s_in),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .out_state (s_out),
      .out_valid (s_out_valid),
      .out_ready (1'b1)
    );

    initial begin
      logic [127:0] v;
      int lat;
      bit ok;
      s_in_valid = 1'b0;
      s_in = '0;
      #25;
      for (int t = 0; t < 4; t++) begin
        case (t)
          0: v = VEC;
          1: v = {16{8'h63}};
          2: v = {16{8'hff}};
          default: v = rand128();
        endcase
        @(posedge clk); #1;
        s_in = v;
        s_in_valid = 1'b1;
        ok = 0;
        for (int k = 0; k < 60; k++) begin
          @(negedge clk);
          if (s_in_ready) begin ok = 1; break; end
        end
        chk($sformatf("alt%0d_accept", P), ok, 1);
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        s_in = rand128();
        lat = 0;
        for (int k = 0; k < 60; k++) begin
          @(negedge clk);
          if (s_out_valid) break;
          lat++;
        end
        chk($sformatf("alt%0d_latency", P), lat, 16 / P);
        chk($sformatf("alt%0d_data", P), s_out, inv_sub(v));
      end
      sub_done++;
    end
  end

  // ---------------- main stimulus ----------------
  task automatic send(input logic [127:0] v);
    bit ok = 0;
    @(posedge clk); #1;
    in_state = v;
    in_valid = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    chk("accept", ok, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_state = rand128();
  endtask

  // Returns at the negedge where out_valid is first seen; in_state is
  // scrambled every cycle meanwhile.
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (out_valid) return;
      lat++;
      @(posedge clk); #1;
      in_state = rand128();
    end
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_in_ready"}, in_ready, 1);
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_out_state"}, out_state, 128'h0);
  endtask

  initial begin
    logic [127:0] v;
    int lat, n, a0, d0;
    bit hs;
    rst = 1'b1; rst_s = 1'b1; clear = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; in_state = '0;
    #3;
    check_reset_vals("reset");
    chk("model_00", invtab[8'h00], 8'h52);
    chk("model_63", invtab[8'h63], 8'h00);
    chk("model_ff", invtab[8'hff], 8'h7d);
    chk("model_ed", invtab[8'hed], 8'h53);
    #19;
    rst = 1'b0; rst_s = 1'b0;

    // FIPS-style vector
    send(VEC);
    wait_valid(lat);
    chk("vec_latency", lat, 4);
    chk("vec_data", out_state, VEXP);
    chk("vec_in_ready_in_done", in_ready, 0);
    @(negedge clk);
    chk("vec_in_ready_after", in_ready, 1);

    send({16{8'h63}});
    wait_valid(lat);
    chk("all63_data", out_state, 128'h0);
    send({16{8'hff}});
    wait_valid(lat);
    chk("allff_data", out_state, {16{8'h7d}});

    // backpressure with a stray in_valid pulse
    @(posedge clk); #1 out_ready = 1'b0;
    v = rand128();
    send(v);
    wait_valid(lat);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      in_valid = (c == 2);
      in_state = rand128();
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_state", out_state, inv_sub(v));
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);

    // random input scrambling while busy
    for (int r = 0; r < 3; r++) begin
      v = rand128();
      send(v);
      wait_valid(lat);
      chk("scramble_data", out_state, inv_sub(v));
    end

    // clear on 2nd busy cycle
    send(rand128());
    @(posedge clk); #1 clear = 1'b1;
    @(negedge clk);
    chk("clr_in_ready_low", in_ready, 0);
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    chk("clr_in_ready", in_ready, 1);
    chk("clr_out_valid", out_valid, 0);
    // clear with simultaneous in_valid in IDLE
    @(posedge clk); #1;
    clear = 1'b1; in_valid = 1'b1; in_state = rand128();
    @(negedge clk);
    chk("clr_blocks_ready", in_ready, 0);
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("clr_not_accepted", in_ready, 1);
    send({16{8'h63}});
    wait_valid(lat);
    chk("clr_after_latency", lat, 4);
    chk("clr_after_data", out_state, 128'h0);

    // async reset mid-BUSY
    send(rand128());
    @(posedge clk); #2 rst = 1'b1;
    #1 check_reset_vals("rst_busy");
    #1 rst = 1'b0;
    // async reset mid-DONE
    @(posedge clk); #1 out_ready = 1'b0;
    send(rand128());
    wait_valid(lat);
    @(posedge clk); #2 rst = 1'b1;
    #1 check_reset_vals("rst_done");
    #1 rst = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;

    // back-to-back stream
    a0 = acc; d0 = dlv; n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_state = rand128();
    for (int cyc = 0; cyc < 3000 && n < 100; cyc++) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk); #1;
      if (hs) begin
        n++;
        in_state = rand128();
        if (n == 100) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    chk("stream_accepted", acc - a0, 100);
    chk("stream_delivered", dlv - d0, 100);

    for (int k = 0; k < 2000 && sub_done < 4; k++) @(posedge clk);
    chk("alt_complete", sub_done, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
